// File: rtl/axi_lite_write_sequencer.sv
// Boot-time AXI4-Lite register writer that hands the port to one external requester once the table is done.
// Define SEQ_READBACK_EN to read back every write over AR/R and flag data mismatches.
module axi_lite_write_sequencer #(
  parameter int ADDR_W = 4,
  parameter int NUM_INIT = 4,
  parameter logic [NUM_INIT*ADDR_W-1:0] INIT_ADDR = '0,
  parameter logic [NUM_INIT*32-1:0] INIT_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              init_done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clear,
`ifdef SEQ_READBACK_EN
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              rb_mismatch,
`endif
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT - 1);

`ifdef SEQ_READBACK_EN
  typedef enum logic [2:0] {INIT_ISSUE, ISSUE, RESP, IDLE, RB_ADDR, RB_DATA} state_t;
`else
  typedef enum logic [1:0] {INIT_ISSUE, ISSUE, RESP, IDLE} state_t;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } beat_t;

  state_t state, state_d;
  beat_t  cur;
  logic [IDX_W-1:0] idx;
  logic from_init, restart_pend;
  logic load_init, load_req, step, more_init, b_err;

  // Table padded to 16 entries so the 4-bit index always selects a real element.
  beat_t tab [16];
  for (genvar g = 0; g < 16; g++) begin : g_tab
    if (g < NUM_INIT) begin : g_used
      assign tab[g] = '{addr: INIT_ADDR[g*ADDR_W +: ADDR_W], data: INIT_DATA[g*32 +: 32]};
    end else begin : g_pad
      assign tab[g] = '0;
    end
  end

  assign m_awaddr  = cur.addr;
  assign m_wdata   = cur.data;
  assign m_awprot  = 3'b000;
  assign m_wstrb   = 4'hf;
  assign m_bready  = (state == RESP);
  assign req_ready = (state == IDLE) & init_done & ~restart_pend & ~restart;
  assign more_init = from_init & (idx < LAST_IDX);
  assign b_err     = (state == RESP) & m_bvalid & m_bresp[1];

`ifdef SEQ_READBACK_EN
  logic rb_bad;
  assign m_araddr  = cur.addr;
  assign m_arvalid = (state == RB_ADDR);
  assign m_rready  = (state == RB_DATA);
  assign rb_bad    = (state == RB_DATA) & m_rvalid & ((m_rdata != cur.data) | m_rresp[1]);
`endif

  always_comb begin
    state_d   = state;
    load_init = 1'b0;
    load_req  = 1'b0;
    step      = 1'b0;
    case (state)
      INIT_ISSUE: begin
        load_init = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: if (!(m_awvalid & ~m_awready) && !(m_wvalid & ~m_wready)) state_d = RESP;
`ifdef SEQ_READBACK_EN
      RESP:    if (m_bvalid) state_d = RB_ADDR;
      RB_ADDR: if (m_arready) state_d = RB_DATA;
      RB_DATA: if (m_rvalid) step = 1'b1;
`else
      RESP: if (m_bvalid) step = 1'b1;
`endif
      IDLE: begin
        if (restart_pend) state_d = INIT_ISSUE;
        else if (req_valid & req_ready) begin
          load_req = 1'b1;
          state_d  = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (step) state_d = more_init ? INIT_ISSUE : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT_ISSUE;
      idx          <= '0;
      from_init    <= 1'b0;
      init_done    <= 1'b0;
      busy         <= 1'b0;
      restart_pend <= 1'b0;
      cur          <= '0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      err          <= 1'b0;
      err_addr     <= '0;
    end else begin
      state        <= state_d;
      busy         <= (state_d != IDLE);
      // A restart seen anywhere is held until IDLE, so in-flight writes always finish first.
      restart_pend <= restart | (restart_pend & (state != IDLE));
      if (state == IDLE && restart_pend) begin
        idx       <= '0;
        init_done <= 1'b0;
      end
      if (load_init || load_req) begin
        cur       <= load_init ? tab[idx] : '{addr: req_addr, data: req_data};
        from_init <= load_init;
        m_awvalid <= 1'b1;
        m_wvalid  <= 1'b1;
      end else begin
        if (m_awvalid && m_awready) m_awvalid <= 1'b0;
        if (m_wvalid && m_wready) m_wvalid <= 1'b0;
      end
      if (step && more_init) idx <= idx + 1'b1;
      if (step && from_init && !more_init) init_done <= 1'b1;
      if (err_clear) begin
        err      <= 1'b0;
        err_addr <= '0;
      end
      // A new error beats a same-cycle clear and then records its own address.
      if (b_err) begin
        err <= 1'b1;
        if (!err || err_clear) err_addr <= cur.addr;
      end
    end
  end

`ifdef SEQ_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rb_mismatch <= 1'b0;
    else if (rb_bad) rb_mismatch <= 1'b1;
    else if (err_clear) rb_mismatch <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_axi_lite_write_sequencer.sv
// Directed bench for axi_lite_write_sequencer: boot table, stalled AW, errors, restart and async reset.
module tb_axi_lite_write_sequencer;
  logic clk = 1'b0;
  logic rst_n, restart, req_valid, req_ready, init_done, busy, err, err_clear;
  logic [3:0] req_addr, err_addr, m_awaddr;
  logic [31:0] req_data, m_wdata;
  logic [2:0] m_awprot;
  logic [3:0] m_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0] m_bresp;
  logic inj_en;
  logic [3:0] inj_addr;
`ifdef SEQ_READBACK_EN
  logic [3:0] m_araddr;
  logic m_arvalid, m_rready, rb_mismatch;
`endif

  int n_cmp = 0, n_bad = 0;
  logic [3:0]  aw_log [32];
  logic [31:0] w_log [32];
  int aw_n = 0, w_n = 0;
  int base;

  always #5 clk = ~clk;

  assign m_bresp = (inj_en && m_awaddr == inj_addr) ? 2'b10 : 2'b00;

  axi_lite_write_sequencer #(
    .ADDR_W(4), .NUM_INIT(4),
    .INIT_ADDR(16'hc840),
    .INIT_DATA({32'h0, 32'h3, 32'h100, 32'h1})
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .init_done(init_done), .busy(busy), .err(err), .err_addr(err_addr), .err_clear(err_clear),
`ifdef SEQ_READBACK_EN
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(1'b1),
    .m_rdata(m_wdata), .m_rresp(2'b00), .m_rvalid(1'b1), .m_rready(m_rready),
    .rb_mismatch(rb_mismatch),
`endif
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  // Handshake log, read back only at negedges.
  always @(posedge clk) begin
    if (m_awvalid && m_awready) begin
      aw_log[aw_n] <= m_awaddr;
      aw_n <= aw_n + 1;
    end
    if (m_wvalid && m_wready) begin
      w_log[w_n] <= m_wdata;
      w_n <= w_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    err_clear = 1'b0; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    inj_en = 1'b0; inj_addr = '0;
    cyc(2);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("awprot", m_awprot, 0);
    chk("wstrb", m_wstrb, 4'hf);

    // Boot table at full throughput: done on edge 12.
    rst_n = 1'b1;
    cyc(11);
    chk("boot_not_done_c11", init_done, 0);
    chk("boot_req_ready_c11", req_ready, 0);
    cyc(1);
    chk("boot_done_c12", init_done, 1);
    chk("boot_req_ready", req_ready, 1);
    chk("boot_busy", busy, 0);
    chk("boot_aw_cnt", aw_n, 4);
    chk("boot_aw0", aw_log[0], 4'h0);
    chk("boot_aw1", aw_log[1], 4'h4);
    chk("boot_aw2", aw_log[2], 4'h8);
    chk("boot_aw3", aw_log[3], 4'hc);
    chk("boot_w0", w_log[0], 32'h1);
    chk("boot_w1", w_log[1], 32'h100);
    chk("boot_w2", w_log[2], 32'h3);
    chk("boot_w3", w_log[3], 32'h0);

    // External write with AW stalled, W immediate.
    m_awready = 1'b0; req_valid = 1'b1; req_addr = 4'h8; req_data = 32'hdeadbeef;
    cyc(1);
    req_valid = 1'b0;
    chk("ext_awvalid_1", m_awvalid, 1);
    chk("ext_wvalid_1", m_wvalid, 1);
    chk("ext_awaddr", m_awaddr, 4'h8);
    chk("ext_wdata", m_wdata, 32'hdeadbeef);
    chk("ext_busy", busy, 1);
    chk("ext_req_ready_busy", req_ready, 0);
    cyc(1);
    chk("ext_wvalid_drop", m_wvalid, 0);
    chk("ext_awvalid_2", m_awvalid, 1);
    chk("ext_awaddr_stable", m_awaddr, 4'h8);
    cyc(1);
    chk("ext_awvalid_3", m_awvalid, 1);
    m_awready = 1'b1;
    cyc(1);
    chk("ext_awvalid_drop", m_awvalid, 0);
    chk("ext_bready", m_bready, 1);
    cyc(1);
    chk("ext_bready_drop", m_bready, 0);
    chk("ext_req_ready_back", req_ready, 1);
    chk("ext_aw_cnt", aw_n, 5);
    chk("ext_w_cnt", w_n, 5);
    chk("ext_aw_log", aw_log[4], 4'h8);
    chk("ext_w_log", w_log[4], 32'hdeadbeef);

    // Restart during an external write; a held request waits for the new init_done.
    m_awready = 1'b0; req_valid = 1'b1; req_addr = 4'h4; req_data = 32'h55;
    cyc(1);
    req_addr = 4'hc; req_data = 32'h77; restart = 1'b1;
    cyc(1);
    restart = 1'b0; m_awready = 1'b1;
    chk("rs_inflight_aw", m_awvalid, 1);
    chk("rs_init_done_held", init_done, 1);
    cyc(2);
    chk("rs_idle_req_ready", req_ready, 0);
    chk("rs_inflight_logged", aw_log[5], 4'h4);
    chk("rs_inflight_data", w_log[5], 32'h55);
    cyc(1);
    chk("rs_init_done_low", init_done, 0);
    chk("rs_busy", busy, 1);
    cyc(11);
    chk("rs_not_done", init_done, 0);
    chk("rs_aw_cnt", aw_n, 10);
    chk("rs_entry0", aw_log[6], 4'h0);
    chk("rs_entry3", aw_log[9], 4'hc);
    cyc(1);
    chk("rs_done", init_done, 1);
    chk("rs_req_ready", req_ready, 1);
    cyc(1);
    req_valid = 1'b0;
    chk("rs_req_awaddr", m_awaddr, 4'hc);
    chk("rs_req_wdata", m_wdata, 32'h77);
    cyc(2);
    chk("rs_req_aw_cnt", aw_n, 11);
    chk("rs_req_logged", w_log[10], 32'h77);

    // Async reset mid-ISSUE, then reboot with an error on entry 1.
    m_awready = 1'b0; m_wready = 1'b0; req_valid = 1'b1; req_addr = 4'h8; req_data = 32'h99;
    cyc(1);
    req_valid = 1'b0;
    chk("ar_awvalid_pre", m_awvalid, 1);
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_awvalid", m_awvalid, 0);
    chk("ar_wvalid", m_wvalid, 0);
    chk("ar_init_done", init_done, 0);
    chk("ar_busy", busy, 0);
    inj_en = 1'b1; inj_addr = 4'h4; m_awready = 1'b1; m_wready = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    base = aw_n;
    chk("ar_abandoned", aw_n, 11);
    cyc(11);
    chk("ar_not_done", init_done, 0);
    cyc(1);
    chk("ar_done", init_done, 1);
    chk("ar_aw_cnt", aw_n, base + 4);
    chk("ar_entry0", aw_log[base], 4'h0);
    chk("ar_entry1", aw_log[base + 1], 4'h4);
    chk("ar_entry3_data", w_log[base + 3], 32'h0);
    chk("err_set", err, 1);
    chk("err_addr_first", err_addr, 4'h4);

    // Second error keeps the first address.
    inj_addr = 4'hc; req_valid = 1'b1; req_addr = 4'hc; req_data = 32'h12;
    cyc(1);
    req_valid = 1'b0;
    cyc(2);
    chk("err2_sticky", err, 1);
    chk("err2_addr_kept", err_addr, 4'h4);

    // Clear and new error in the same cycle: the new error wins.
    req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    cyc(1);
    chk("err3_in_resp", m_bready, 1);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    chk("err3_wins", err, 1);
    chk("err3_new_addr", err_addr, 4'hc);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    chk("err_cleared", err, 0);
    chk("err_addr_cleared", err_addr, 0);
    chk("end_req_ready", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_write_sequencer.md
Name: axi_lite_write_sequencer

Overview:
Single-master AXI4-Lite write controller that configures the SDR core's register block.
- After reset, replays a parameterised table of (address, data) writes, e.g. spectrometer integration and recorder setup.
- Then grants the shared AXI4-Lite port to one external requester.
- Serialises all accesses, allows one outstanding transaction, and flags error responses.
- Sits between the control/bring-up logic and the s_axi_lite slave port of the top-level core.

Parameters:
ADDR_W, 4, AXI address width (register map word-addressed by bits [3:2]).
NUM_INIT, 4, number of boot-time writes (1..16).
INIT_ADDR, 0, flattened NUM_INIT*ADDR_W table; entry i at bits [i*ADDR_W +: ADDR_W].
INIT_DATA, 0, flattened NUM_INIT*32 table; entry i at bits [i*32 +: 32].

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
restart  in  1  pulse: rerun the init table.
req_valid  in  1  external write request.
req_ready  out  1  external request accepted when req_valid&req_ready.
req_addr  in  ADDR_W  external write address.
req_data  in  32  external write data.
init_done  out  1  high once the init table has completed; low while it (re)runs.
busy  out  1  a transaction is in flight.
err  out  1  sticky: any BRESP[1]==1 seen.
err_addr  out  ADDR_W  address of the first erroring write.
err_clear  in  1  clears err and err_addr.
m_awaddr  out  ADDR_W  AXI write address.
m_awprot  out  3  constant 3'b000.
m_awvalid  out  1  write-address valid.
m_awready  in  1  write-address ready.
m_wdata  out  32  write data.
m_wstrb  out  4  constant 4'hf.
m_wvalid  out  1  write-data valid.
m_wready  in  1  write-data ready.
m_bresp  in  2  write response.
m_bvalid  in  1  response valid.
m_bready  out  1  response ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: m_awvalid = m_wvalid = m_bready = 0; req_ready = 0; init_done = 0; busy = 0; err = 0; err_addr = 0; m_awaddr = 0; m_wdata = 0.
  - Index = 0; state = INIT_ISSUE on the first clock after release.
  - Reset mid-transaction abandons it; the slave is reset by the same rst_n.
- States:
  - INIT_ISSUE: load table entry index; assert m_awvalid and m_wvalid together; go to ISSUE.
  - ISSUE:
    - m_awvalid drops on the cycle after the AW handshake; m_wvalid drops on the cycle after the W handshake (independently; either order, or the same cycle).
    - When both are done, go to RESP.
    - Address and data stay stable while valid.
  - RESP:
    - m_bready = 1.
    - On bvalid: if bresp[1] is set, err <= 1 and, if err was 0, err_addr <= current address.
    - Next state: if the write came from init and index < NUM_INIT-1, index++ and go to INIT_ISSUE; else go to IDLE.
    - init_done <= 1 when the last init entry completes.
  - IDLE:
    - req_ready = 1 only here and only if init_done = 1 and no restart is pending.
    - On req_valid&req_ready, register req_addr/req_data; AW/W valid assert the next cycle (1-cycle latency); go to ISSUE.
- Arbitration:
  - Init has absolute priority.
  - restart in any state sets pending; in IDLE, pending clears index and init_done and goes to INIT_ISSUE.
  - restart and req_valid in the same IDLE cycle: req_ready is already 0 that cycle, so the request waits.
  - An in-flight transaction always completes before a restart takes effect.
- Other signals:
  - busy = 1 in every state except IDLE.
  - Errored writes do not stop the sequence.
  - err_clear and a new error in the same cycle: the error wins (err = 1, err_addr = new address).
- Throughput: with awready = wready = bvalid = 1 constantly, each write takes 3 cycles (ISSUE, RESP, next issue/IDLE). The init table of 4 finishes, and init_done rises, at cycle 12 after reset release.

Optional Feature:
SEQ_READBACK_EN:
- When defined, adds ports:
  - m_araddr out ADDR_W, m_arvalid out 1, m_arready in 1.
  - m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1.
  - rb_mismatch out 1 (sticky; cleared by err_clear).
- Adds states RB_ADDR and RB_DATA after every RESP:
  - RB_ADDR issues an AR to the same address.
  - RB_DATA waits for R with m_rready = 1.
  - rdata != written data, or rresp[1], sets rb_mismatch.
  - Sequencing then continues as from RESP.
- Without the macro, the ports and states are absent and RESP transitions directly.

Test Plan:
- Reset release, NUM_INIT = 4, tables {0x0:0x1, 0x4:0x100, 0x8:0x3, 0xc:0x0}, all readies 1 -> four AW/W pairs in table order, init_done high at cycle 12, req_ready high afterwards.
- External write addr 0x8, data 0xdeadbeef with awready delayed 3 cycles, wready immediate -> m_wvalid drops after 1 cycle, m_awvalid held 3 cycles, both stable; single B accepted; req_ready returns.
- bresp = 2'b10 on init entry 1, then on an external write to 0xc -> err = 1, err_addr = 0x4 (first error kept); err_clear -> both 0.
- restart pulsed during an external transaction -> that write completes, then init_done = 0 and table rewrite from entry 0; req_valid held throughout is accepted only after the new init_done.
- rst_n asserted mid-ISSUE -> all valids 0 immediately (asynchronous); after release, sequence restarts at entry 0.
- With SEQ_READBACK_EN defined, slave returns rdata 0x101 for a write of 0x100 -> rb_mismatch = 1, sequence continues to the next entry.
